// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) for the 8-bit single-bus CPU.
// Optional SINGLE_STEP_EN macro adds a latched `step` input that gates each instruction fetch.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] instruction,
  input  logic       alu_zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       branch,
  output logic       memtoreg,
  output logic       memread,
  output logic       memwrite,
  output logic       aluop,
  output logic       alusrc,
  output logic       regwrite,
  output logic       regdst,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       mem_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BEQZ  = 2'b11;

  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  // Last wait cycle: the counter would reach MEM_TIMEOUT on this cycle's increment.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t           state_q, state_d;
  logic [1:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_go;
  logic             unused_instr;

  assign unused_instr = ^instruction[5:0];
  assign state        = state_q;

`ifdef SINGLE_STEP_EN
  logic step_q, step_d;
  assign fetch_go = step_q | step;
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    cnt_d      = cnt_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    memtoreg   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    aluop      = 1'b0;
    alusrc     = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    instr_done = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req = fetch_go;
        if (fetch_go && imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        opcode_d = instruction[7:6];
        state_d  = S_EXEC;
      end

      S_EXEC: begin
        case (opcode_q)
          OP_ADD: begin
            aluop   = 1'b1;
            regdst  = 1'b1;
            state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alusrc  = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQZ: begin
            branch     = 1'b1;
            pc_write   = alu_zero;
            pc_src     = alu_zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        alusrc   = 1'b1;
        memread  = (opcode_q == OP_LOAD);
        memtoreg = (opcode_q == OP_LOAD);
        memwrite = (opcode_q == OP_STORE);
        // Ready is checked first so a completion on the last allowed cycle is not an error.
        if (dmem_ready) begin
          cnt_d = '0;
          if (opcode_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          mem_err = 1'b1;
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        regwrite   = 1'b1;
        regdst     = (opcode_q == OP_ADD);
        memtoreg   = (opcode_q == OP_LOAD);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

`ifdef SINGLE_STEP_EN
    // A step seen in any state arms the next fetch; retire or abort disarms it.
    step_d = step | (step_q & ~(instr_done | mem_err));
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      opcode_q <= 2'b00;
      cnt_q    <= '0;
`ifdef SINGLE_STEP_EN
      step_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
`ifdef SINGLE_STEP_EN
      step_q   <= step_d;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: one linear sequence of steps with hand-computed
// state/strobe expectations; MEM_TIMEOUT is set to 4 to reach the abort path quickly.
module tb_multicycle_sequencer;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] instruction;
  logic       alu_zero, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, pc_write, pc_src, ir_write;
  logic       branch, memtoreg, memread, memwrite, aluop, alusrc, regwrite, regdst;
  logic [2:0] state;
  logic       instr_done, mem_err;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5;

  localparam logic [14:0] IREQ   = 15'h4000, DREQ   = 15'h2000, PCW    = 15'h1000,
                          PCSRC  = 15'h0800, IRW    = 15'h0400, BR     = 15'h0200,
                          M2R    = 15'h0100, MRD    = 15'h0080, MWR    = 15'h0040,
                          ALUOP  = 15'h0020, ALUSRC = 15'h0010, REGW   = 15'h0008,
                          REGDST = 15'h0004, DONE   = 15'h0002, MERR   = 15'h0001;
  localparam logic [14:0] FHIT   = IREQ | PCW | IRW;

  logic [14:0] ctrl;
  assign ctrl = {imem_req, dmem_req, pc_write, pc_src, ir_write, branch, memtoreg, memread,
                 memwrite, aluop, alusrc, regwrite, regdst, instr_done, mem_err};

  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .instruction(instruction), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .branch(branch), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .aluop(aluop), .alusrc(alusrc), .regwrite(regwrite),
    .regdst(regdst), .state(state), .instr_done(instr_done), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] c);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_ctrl"},  32'(ctrl),  32'(c));
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RESET_N     = 1'b0;
    instruction = 8'h00;
    alu_zero    = 1'b0;
    imem_ready  = 1'b1;
    dmem_ready  = 1'b1;
`ifdef SINGLE_STEP_EN
    step        = 1'b1;
`endif
    #2;
    cyc("rst", ST_IDLE, 15'h0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    tick;
    tick;
    RESET_N = 1'b1;

    // R-type add: 0,1,2,3,5,1
    cyc("r_idle", ST_IDLE, 15'h0);
    tick; cyc("r_fetch", ST_FETCH, FHIT);
    tick; cyc("r_dec",   ST_DECODE, 15'h0);
    tick; cyc("r_exec",  ST_EXEC, ALUOP | REGDST);
    tick; cyc("r_wb",    ST_WB, REGW | REGDST | DONE);
    tick;

    // Load with a fetch stall and three data wait cycles; ready on the last allowed cycle
    instruction = 8'h40;
    imem_ready  = 1'b0;
    dmem_ready  = 1'b0;
    cyc("l_fwait", ST_FETCH, IREQ);
    tick; imem_ready = 1'b1;
    cyc("l_fetch", ST_FETCH, FHIT);
    tick; cyc("l_dec",  ST_DECODE, 15'h0);
    tick; cyc("l_exec", ST_EXEC, ALUSRC);
    for (int i = 0; i < 3; i++) begin
      tick; cyc("l_mwait", ST_MEM, DREQ | ALUSRC | MRD | M2R);
    end
    tick; dmem_ready = 1'b1;
    cyc("l_mrdy", ST_MEM, DREQ | ALUSRC | MRD | M2R);
    tick; cyc("l_wb", ST_WB, REGW | M2R | DONE);
    tick;

    // Store with data memory never ready: abort after 4 MEM cycles
    instruction = 8'h80;
    dmem_ready  = 1'b0;
    cyc("s_fetch", ST_FETCH, FHIT);
    tick; cyc("s_dec",  ST_DECODE, 15'h0);
    tick; cyc("s_exec", ST_EXEC, ALUSRC);
    for (int i = 0; i < 3; i++) begin
      tick; cyc("s_mwait", ST_MEM, DREQ | ALUSRC | MWR);
    end
    tick; cyc("s_mto", ST_MEM, DREQ | ALUSRC | MWR | MERR);
    tick; cyc("s_back", ST_FETCH, FHIT);
    chk("s_cnt", 32'(dut.cnt_q), 32'd0);

    // Branch taken
    instruction = 8'hC0;
    alu_zero    = 1'b1;
    dmem_ready  = 1'b1;
    tick; cyc("b1_dec",  ST_DECODE, 15'h0);
    tick; cyc("b1_exec", ST_EXEC, BR | PCW | PCSRC | DONE);
    tick; alu_zero = 1'b0;
    cyc("b0_fetch", ST_FETCH, FHIT);
    tick; cyc("b0_dec",  ST_DECODE, 15'h0);
    tick; cyc("b0_exec", ST_EXEC, BR | DONE);
    tick; cyc("b0_back", ST_FETCH, FHIT);

    // Asynchronous reset in the middle of a load's MEM wait
    instruction = 8'h40;
    dmem_ready  = 1'b0;
    tick; tick;
    tick; cyc("x_mem", ST_MEM, DREQ | ALUSRC | MRD | M2R);
    RESET_N = 1'b0;
    cyc("x_rst", ST_IDLE, 15'h0);
    chk("x_cnt", 32'(dut.cnt_q), 32'd0);
    tick; RESET_N = 1'b1;
    cyc("x_idle", ST_IDLE, 15'h0);
    tick; cyc("x_fetch", ST_FETCH, FHIT);

`ifdef SINGLE_STEP_EN
    // One step pulse per instruction; fetch holds off until it arrives
    step        = 1'b0;
    instruction = 8'h00;
    dmem_ready  = 1'b1;
    tick; tick; tick; tick;
    cyc("st_hold", ST_FETCH, 15'h0);
    tick; cyc("st_hold2", ST_FETCH, 15'h0);
    step = 1'b1;
    cyc("st_go", ST_FETCH, FHIT);
    tick; step = 1'b0;
    cyc("st_dec", ST_DECODE, 15'h0);
    tick; tick;
    cyc("st_wb", ST_WB, REGW | REGDST | DONE);
    tick; cyc("st_wait", ST_FETCH, 15'h0);
    tick; cyc("st_wait2", ST_FETCH, 15'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
